// File: rtl/matmul_controller.sv
// matmul_controller: sequences operand load, MAC and write-back for C = A x B.
// Define MATMUL_CTRL_LOAD_EN to stream A and B in through in_valid/in_ready.
module matmul_controller #(
    parameter int ROWS  = 4,
    parameter int INNER = 4,
    parameter int COLS  = 4,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          m1EN,
    output logic          m1rEN,
    output logic          m1wEN,
    output logic          m2EN,
    output logic          m2rEN,
    output logic          m2wEN,
    output logic          m3EN,
    output logic          m3rEN,
    output logic          m3wEN,
    output logic          mult_ld,
    output logic          mult_rst,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic [AW-1:0] addr3,
    output logic          busy,
    output logic          done
);

    localparam int N1   = ROWS * INNER;
    localparam int N2   = INNER * COLS;
    localparam int N3   = ROWS * COLS;
    localparam int N12  = (N1 > N2) ? N1 : N2;
    localparam int NMAX = (N12 > N3) ? N12 : N3;
    localparam int PW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW   = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int JW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [IW-1:0] ILAST = IW'(ROWS - 1);
    localparam logic [KW-1:0] KLAST = KW'(INNER - 1);
    localparam logic [JW-1:0] JLAST = JW'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        CLR,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d;
    logic          ld_q;
    logic          rd_stb;
    logic [PW-1:0] a1, a2, a3;
    logic [PW-1:0] mac_a1, mac_a2, wr_a3;

    // Products never exceed NMAX-1, so PW-bit modular arithmetic is exact.
    assign mac_a1 = PW'(i_q) * PW'(INNER) + PW'(k_q);
    assign mac_a2 = PW'(k_q) * PW'(COLS) + PW'(j_q);
    assign wr_a3  = PW'(i_q) * PW'(COLS) + PW'(j_q);

`ifdef MATMUL_CTRL_LOAD_EN
    localparam logic [PW-1:0] B1LAST = PW'(N1 - 1);
    localparam logic [PW-1:0] B2LAST = PW'(N2 - 1);

    logic [PW-1:0] beat_q, beat_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            j_q     <= j_d;
            ld_q    <= rd_stb;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        j_d      = j_q;
`ifdef MATMUL_CTRL_LOAD_EN
        beat_d   = beat_q;
`endif
        in_ready = 1'b0;
        m1EN     = 1'b0;
        m1rEN    = 1'b0;
        m1wEN    = 1'b0;
        m2EN     = 1'b0;
        m2rEN    = 1'b0;
        m2wEN    = 1'b0;
        m3EN     = 1'b0;
        m3rEN    = 1'b0;
        m3wEN    = 1'b0;
        mult_rst = 1'b0;
        rd_stb   = 1'b0;
        a1       = '0;
        a2       = '0;
        a3       = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    i_d = '0;
                    k_d = '0;
                    j_d = '0;
`ifdef MATMUL_CTRL_LOAD_EN
                    beat_d  = '0;
                    state_d = LOAD1;
`else
                    state_d = CLR;
`endif
                end
            end
`ifdef MATMUL_CTRL_LOAD_EN
            LOAD1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m1EN  = 1'b1;
                    m1wEN = 1'b1;
                    a1    = beat_q;
                    if (beat_q == B1LAST) begin
                        beat_d  = '0;
                        state_d = LOAD2;
                    end else begin
                        beat_d = beat_q + PW'(1);
                    end
                end
            end
            LOAD2: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m2EN  = 1'b1;
                    m2wEN = 1'b1;
                    a2    = beat_q;
                    if (beat_q == B2LAST) begin
                        beat_d  = '0;
                        state_d = CLR;
                    end else begin
                        beat_d = beat_q + PW'(1);
                    end
                end
            end
`endif
            CLR: begin
                mult_rst = 1'b1;
                k_d      = '0;
                state_d  = MAC;
            end
            MAC: begin
                rd_stb = 1'b1;
                m1EN   = 1'b1;
                m1rEN  = 1'b1;
                m2EN   = 1'b1;
                m2rEN  = 1'b1;
                a1     = mac_a1;
                a2     = mac_a2;
                if (k_q == KLAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            // Last read data lands here; mult_ld consumes it via ld_q.
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                m3EN    = 1'b1;
                m3wEN   = 1'b1;
                a3      = wr_a3;
                state_d = CLR;
                if (j_q == JLAST) begin
                    j_d = '0;
                    if (i_q == ILAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign addr1   = AW'(a1);
    assign addr2   = AW'(a2);
    assign addr3   = AW'(a3);
    assign mult_ld = ld_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: schedule model plus a memory/MAC datapath model.
// Define MATMUL_CTRL_LOAD_EN to cover the streaming load phase (4x4x4).
module tb_matmul_controller;

`ifdef MATMUL_CTRL_LOAD_EN
    localparam int R       = 4;
    localparam int K       = 4;
    localparam int C       = 4;
    localparam int KLIT    = 4;
    localparam int P2      = 24;
    localparam int LAT_TOT = 144;
    localparam int LAT_CMP = 112;
    localparam int LAT_RST = 33;
`else
    localparam int R       = 2;
    localparam int K       = 3;
    localparam int C       = 2;
    localparam int KLIT    = 3;
    localparam int P2      = 18;
    localparam int LAT_TOT = 24;
    localparam int LAT_CMP = 24;
    localparam int LAT_RST = 1;
`endif
    localparam int AW   = 16;
    localparam int EL   = K + 3;
    localparam int CMPN = R * C * EL;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic          in_ready;
    logic          m1EN, m1rEN, m1wEN;
    logic          m2EN, m2rEN, m2wEN;
    logic          m3EN, m3rEN, m3wEN;
    logic          mult_ld, mult_rst;
    logic [AW-1:0] addr1, addr2, addr3;
    logic          busy, done;
    int            din;

    matmul_controller #(
        .ROWS (R),
        .INNER(K),
        .COLS (C),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .m1EN    (m1EN),
        .m1rEN   (m1rEN),
        .m1wEN   (m1wEN),
        .m2EN    (m2EN),
        .m2rEN   (m2rEN),
        .m2wEN   (m2wEN),
        .m3EN    (m3EN),
        .m3rEN   (m3rEN),
        .m3wEN   (m3wEN),
        .mult_ld (mult_ld),
        .mult_rst(mult_rst),
        .addr1   (addr1),
        .addr2   (addr2),
        .addr3   (addr3),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Datapath: synchronous-read memories and an accumulator.
    int mem1 [R*K];
    int mem2 [K*C];
    int mem3 [R*C];
    int rd1 = 0, rd2 = 0, acc = 0;

    always @(posedge clk) begin
        if (m3EN && m3wEN && int'(addr3) < R*C) mem3[int'(addr3)] = acc;
        if (mult_rst) acc = 0;
        else if (mult_ld) acc = acc + rd1 * rd2;
        if (m1EN && m1wEN && int'(addr1) < R*K) mem1[int'(addr1)] = din;
        if (m2EN && m2wEN && int'(addr2) < K*C) mem2[int'(addr2)] = din;
        if (m1EN && m1rEN && int'(addr1) < R*K) rd1 = mem1[int'(addr1)];
        if (m2EN && m2rEN && int'(addr2) < K*C) rd2 = mem2[int'(addr2)];
    end

    // Job-level schedule model: phase plus beat / compute-cycle counts.
    typedef enum int {M_IDLE, M_L1, M_L2, M_CMP, M_DONE} mode_t;
    mode_t md = M_IDLE;
    int beats = 0;
    int n = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            md = M_IDLE;
            beats = 0;
            n = 0;
        end else begin
            case (md)
                M_IDLE: if (start) begin
                    beats = 0;
                    n = 0;
`ifdef MATMUL_CTRL_LOAD_EN
                    md = M_L1;
`else
                    md = M_CMP;
`endif
                end
                M_L1: if (in_valid) begin
                    beats++;
                    if (beats == R*K) begin
                        md = M_L2;
                        beats = 0;
                    end
                end
                M_L2: if (in_valid) begin
                    beats++;
                    if (beats == K*C) md = M_CMP;
                end
                M_CMP: begin
                    n++;
                    if (n == CMPN) md = M_DONE;
                end
                default: md = M_IDLE;
            endcase
        end
    end

    logic xb, xd, xr, x1e, x1r, x1w, x2e, x2r, x2w, x3e, x3r, x3w, xl, xc;
    logic [AW-1:0] e1, e2, e3;
    logic [14+3*AW-1:0] act_v, exp_v;
    int el, rr, ii, jj;
    int first_busy = 0, first_rst = -1, done_cyc = 0, ndone = 0;
    int ld_cnt = 0, ld_last = 0;
    bit rst_seen = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        {xb, xd, xr, x1e, x1r, x1w, x2e, x2r, x2w, x3e, x3r, x3w, xl, xc} = '0;
        e1 = '0;
        e2 = '0;
        e3 = '0;
        if (rst) begin
            case (md)
                M_L1: begin
                    xb = 1'b1;
                    xr = 1'b1;
                    if (in_valid) begin
                        x1e = 1'b1;
                        x1w = 1'b1;
                        e1 = AW'(beats);
                    end
                end
                M_L2: begin
                    xb = 1'b1;
                    xr = 1'b1;
                    if (in_valid) begin
                        x2e = 1'b1;
                        x2w = 1'b1;
                        e2 = AW'(beats);
                    end
                end
                M_CMP: begin
                    xb = 1'b1;
                    el = n / EL;
                    rr = n % EL;
                    ii = el / C;
                    jj = el % C;
                    xc = (rr == 0);
                    xl = (rr >= 2 && rr <= K + 1);
                    if (rr >= 1 && rr <= K) begin
                        {x1e, x1r, x2e, x2r} = 4'hf;
                        e1 = AW'(ii * K + rr - 1);
                        e2 = AW'((rr - 1) * C + jj);
                    end
                    if (rr == K + 2) begin
                        x3e = 1'b1;
                        x3w = 1'b1;
                        e3 = AW'(ii * C + jj);
                    end
                end
                M_DONE: begin
                    xb = 1'b1;
                    xd = 1'b1;
                end
                default: ;
            endcase
        end
        exp_v = {xb, xd, xr, x1e, x1r, x1w, x2e, x2r, x2w,
                 x3e, x3r, x3w, xl, xc, e1, e2, e3};
        act_v = {busy, done, in_ready, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN,
                 m3EN, m3rEN, m3wEN, mult_ld, mult_rst, addr1, addr2, addr3};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d got %h want %h", cyc, act_v, exp_v);
        end
        if (busy && !busy_prev) begin
            first_busy = cyc;
            first_rst = -1;
        end
        if (mult_rst && first_rst < 0) first_rst = cyc;
        if (done) begin
            done_cyc = cyc;
            ndone++;
        end
        if (!busy) rst_seen = 0;
        if (mult_ld) ld_cnt++;
        if (mult_rst) begin
            if (rst_seen) begin
                checks++;
                if (ld_cnt != K) begin
                    errors++;
                    $display("FAIL ld_per_elem cyc=%0d got %0d want %0d", cyc, ld_cnt, K);
                end
                ld_last = ld_cnt;
            end
            rst_seen = 1;
            ld_cnt = 0;
        end
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clr3();
        for (int i = 0; i < R*C; i++) mem3[i] = -1;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int g = 0; g < 2000 && !got; g++) begin
            @(negedge clk);
            got = done;
        end
        check(name, int'(got), 1);
        tick();
    endtask

`ifdef MATMUL_CTRL_LOAD_EN
    task automatic stream(input int w[$], input bit tog);
        int idx;
        int g;
        bit took;
        idx = 0;
        g = 0;
        while (idx < w.size() && g < 1000) begin
            in_valid = (tog && idx < R*K) ? (g % 2 == 0) : 1'b1;
            din = w[idx];
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
            if (took) idx++;
            g++;
        end
        in_valid = 1'b0;
        check("stream_complete", idx, w.size());
    endtask

    int wq1[$], wq2[$];
`endif

    int s, tgt, nd0;
    bit hit;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        din = 0;
        #2 rst = 1'b0;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_addr3", int'(addr3), 0);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();

        // Job 1: A=I, B=1..N (load build) or A=1..6, B=7..12 (2x3x2)
`ifdef MATMUL_CTRL_LOAD_EN
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) wq1.push_back((i % 5 == 0) ? 1 : 0);
        for (int i = 0; i < 16; i++) wq1.push_back(i + 1);
        for (int i = 0; i < 16; i++) wq2.push_back(2);
        for (int i = 0; i < 16; i++) wq2.push_back(3);
`else
        for (int i = 0; i < R*K; i++) mem1[i] = i + 1;
        for (int i = 0; i < K*C; i++) mem2[i] = 7 + i;
`endif
        clr3();
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
`ifdef MATMUL_CTRL_LOAD_EN
        stream(wq1, 1'b0);
`endif
        wait_done("job1_done");
        check("first_rst_after_start", first_rst - s, LAT_RST);
        check("done_after_first_rst", done_cyc - first_rst, LAT_CMP);
        check("done_after_first_busy", done_cyc - first_busy, LAT_TOT);
`ifdef MATMUL_CTRL_LOAD_EN
        for (int i = 0; i < 16; i++) check("job1_C", mem3[i], i + 1);
`else
        check("job1_C00", mem3[0], 58);
        check("job1_C01", mem3[1], 64);
        check("job1_C10", mem3[2], 139);
        check("job1_C11", mem3[3], 154);
`endif

        // Job 2: A all 2s, B all 3s; in_valid toggles during LOAD1
`ifndef MATMUL_CTRL_LOAD_EN
        for (int i = 0; i < R*K; i++) mem1[i] = 2;
        for (int i = 0; i < K*C; i++) mem2[i] = 3;
`endif
        clr3();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MATMUL_CTRL_LOAD_EN
        stream(wq2, 1'b1);
`endif
        wait_done("job2_done");
        for (int i = 0; i < R*C; i++) check("job2_C", mem3[i], P2);
        check("job2_ld_pulses", ld_last, KLIT);

        // Job 3: reset during MAC of element (1, min(2,C-1))
        tgt = (C + ((C > 2) ? 2 : C - 1)) * EL + 2;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MATMUL_CTRL_LOAD_EN
        stream(wq2, 1'b0);
`endif
        hit = (md == M_CMP && n == tgt);
        for (int g = 0; g < 2000 && !hit; g++) begin
            tick();
            hit = (md == M_CMP && n == tgt);
        end
        check("reach_mac_target", int'(hit), 1);
        check("pre_reset_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_m1EN", int'(m1EN), 0);
        check("abort_addr1", int'(addr1), 0);
        check("abort_addr2", int'(addr2), 0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("idle_after_abort", int'(busy), 0);

        // Job 4: start held high through a whole job
        clr3();
        nd0 = ndone;
        start = 1'b1;
        tick();
`ifdef MATMUL_CTRL_LOAD_EN
        stream(wq2, 1'b0);
`endif
        wait_done("job4_done");
        check("job4_one_done", ndone - nd0, 1);
        check("job4_idle_cycle", int'(busy), 0);
        tick();
        check("job4_restart", int'(busy), 1);
        start = 1'b0;
        for (int i = 0; i < R*C; i++) check("job4_C", mem3[i], P2);
        clr3();
`ifdef MATMUL_CTRL_LOAD_EN
        stream(wq2, 1'b0);
`endif
        wait_done("job5_done");
        for (int i = 0; i < R*C; i++) check("job5_C", mem3[i], P2);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
